// File: rtl/mc_alu_if.sv
// mc_alu_if: request/response bundle for the multi-cycle ALU.
//   Request side : in_valid, in_ready, a, b, control
//   Response side: out_valid, out_ready, result, cout, zero, overflow, illegal
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload until that edge; the
// consumer may raise or drop ready at any time.
// master = control unit / writeback side, slave = the ALU.
interface mc_alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, a, b, control, out_ready,
        input  in_ready, out_valid, result, cout, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, a, b, control, out_ready,
        output in_ready, out_valid, result, cout, zero, overflow, illegal
    );
endinterface

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle integer ALU with registered results.
//   clk, rst_n  : single clock, asynchronous active-low reset
//   bus         : mc_alu_if slave port (request a/b/control, response
//                 result/cout/zero/overflow/illegal)
//   state_dbg   : current FSM state (IDLE=0, BUSY=1, DONE=2)
// Logic, add, sub and SLT finish in one cycle; MULU is a shift-add multiplier
// and DIVU/REMU a restoring divider, each taking WIDTH iterations.
module mc_alu #(
    parameter int WIDTH  = 64,
    parameter int DIV_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mc_alu_if.slave    bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    // Iteration registers. MULU: acc = partial product, x = shifted
    // multiplicand, y = remaining multiplier bits. DIVU/REMU: acc = partial
    // remainder, x = divisor, y = dividend bits shifting out / quotient in.
    logic [WIDTH-1:0] acc, x, y;
    logic [WIDTH-1:0] res_q;
    logic             cout_q, zero_q, ovf_q, ill_q;

    // ---------------- request decode ----------------
    logic op_div, op_multi;
    always_comb begin
        op_div   = (DIV_EN != 0) && (bus.control == OP_DIVU || bus.control == OP_REMU);
        op_multi = (bus.control == OP_MULU) || op_div;
    end

    // ---------------- single-cycle datapath ----------------
    // SUB and SLT share the adder as a + ~b + 1, so cout is the inverted borrow.
    logic             sub_op, add_ovf, slt_bit;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] s_res;
    logic             s_cout, s_ovf, s_ill;

    always_comb begin
        sub_op  = (bus.control == OP_SUB) || (bus.control == OP_SLT);
        b_eff   = sub_op ? ~bus.b : bus.b;
        sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
        add_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        // Signed less-than: sign of the difference, corrected when it overflowed.
        slt_bit = sum[WIDTH-1] ^ add_ovf;

        s_res  = '0;
        s_cout = 1'b0;
        s_ovf  = 1'b0;
        s_ill  = 1'b0;
        case (bus.control)
            OP_AND: s_res = bus.a & bus.b;
            OP_OR:  s_res = bus.a | bus.b;
            OP_NOR: s_res = ~(bus.a | bus.b);
            OP_ADD, OP_SUB: begin
                s_res  = sum[WIDTH-1:0];
                s_cout = sum[WIDTH];
                s_ovf  = add_ovf;
            end
            OP_SLT: begin
                s_res  = {{(WIDTH-1){1'b0}}, slt_bit};
                s_cout = sum[WIDTH];
            end
            default: s_ill = !op_multi;
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic [WIDTH-1:0] acc_step, x_step, y_step, f_res;
    logic [WIDTH:0]   rem_sh, diff;

    always_comb begin
        rem_sh   = {acc, y[WIDTH-1]};
        diff     = rem_sh - {1'b0, x};
        acc_step = acc;
        x_step   = x;
        y_step   = y;
        if (op_q == OP_MULU) begin
            acc_step = y[0] ? (acc + x) : acc;
            x_step   = x << 1;
            y_step   = y >> 1;
        end else if (!diff[WIDTH]) begin
            // Trial subtraction fits: keep it and shift a 1 into the quotient.
            // A zero divisor always fits, giving quotient all ones, remainder a.
            acc_step = diff[WIDTH-1:0];
            y_step   = {y[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = rem_sh[WIDTH-1:0];
            y_step   = {y[WIDTH-2:0], 1'b0};
        end
        f_res = (op_q == OP_DIVU) ? y_step : acc_step;
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid) state_nx = op_multi ? BUSY : DONE;
            BUSY: if (cnt == CW'(1)) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q <= bus.control;
                    if (op_multi) begin
                        cnt <= CW'(WIDTH);
                        acc <= '0;
                        x   <= op_div ? bus.b : bus.a;
                        y   <= op_div ? bus.a : bus.b;
                    end else begin
                        res_q  <= s_res;
                        cout_q <= s_cout;
                        zero_q <= (s_res == '0);
                        ovf_q  <= s_ovf;
                        ill_q  <= s_ill;
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    x   <= x_step;
                    y   <= y_step;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res_q  <= f_res;
                        cout_q <= 1'b0;
                        zero_q <= (f_res == '0);
                        ovf_q  <= 1'b0;
                        ill_q  <= 1'b0;
                    end
                end
                default: ;  // DONE: outputs held until consumed
            endcase
        end
    end

    // in_ready is gated by rst_n so it stays low while reset is asserted.
    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.illegal   = ill_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: self-checking bench for mc_alu.
// Three instances share clock and reset: sel 0 = WIDTH 8, sel 1 = WIDTH 64,
// sel 2 = WIDTH 8 with divide disabled.
module tb_mc_alu;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_alu_if #(.WIDTH(8))  if8  ();
    mc_alu_if #(.WIDTH(64)) if64 ();
    mc_alu_if #(.WIDTH(8))  if8n ();
    logic [1:0] st8, st64, st8n;

    mc_alu #(.WIDTH(8),  .DIV_EN(1)) u8   (.clk(clk), .rst_n(rst_n), .bus(if8),  .state_dbg(st8));
    mc_alu #(.WIDTH(64), .DIV_EN(1)) u64  (.clk(clk), .rst_n(rst_n), .bus(if64), .state_dbg(st64));
    mc_alu #(.WIDTH(8),  .DIV_EN(0)) u8n  (.clk(clk), .rst_n(rst_n), .bus(if8n), .state_dbg(st8n));

    typedef struct {
        logic        in_ready;
        logic        out_valid;
        logic [63:0] result;
        logic        cout;
        logic        zero;
        logic        overflow;
        logic        illegal;
    } out_t;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    // ---------------- helpers ----------------
    function automatic int width_of(int sel);
        return (sel == 1) ? 64 : 8;
    endfunction

    function automatic logic [63:0] mask_of(int w);
        logic [63:0] one;
        one = 64'd1;
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((one << w) - 64'd1);
    endfunction

    function automatic logic signed [129:0] sx(logic [63:0] v, int w);
        logic signed [129:0] t;
        t = $signed({66'd0, v});
        if (v[w-1]) t = t - (130'sd1 <<< w);
        return t;
    endfunction

    function automatic out_t sample(int sel);
        out_t o;
        case (sel)
            0: begin
                o.in_ready = if8.in_ready;  o.out_valid = if8.out_valid;
                o.result = {56'd0, if8.result};  o.cout = if8.cout;
                o.zero = if8.zero;  o.overflow = if8.overflow;  o.illegal = if8.illegal;
            end
            1: begin
                o.in_ready = if64.in_ready;  o.out_valid = if64.out_valid;
                o.result = if64.result;  o.cout = if64.cout;
                o.zero = if64.zero;  o.overflow = if64.overflow;  o.illegal = if64.illegal;
            end
            default: begin
                o.in_ready = if8n.in_ready;  o.out_valid = if8n.out_valid;
                o.result = {56'd0, if8n.result};  o.cout = if8n.cout;
                o.zero = if8n.zero;  o.overflow = if8n.overflow;  o.illegal = if8n.illegal;
            end
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_in(input int sel, input logic v, input logic [63:0] a,
                            input logic [63:0] b, input logic [3:0] op);
        case (sel)
            0: begin if8.in_valid = v;  if8.a = a[7:0];  if8.b = b[7:0];  if8.control = op; end
            1: begin if64.in_valid = v; if64.a = a;      if64.b = b;      if64.control = op; end
            default: begin if8n.in_valid = v; if8n.a = a[7:0]; if8n.b = b[7:0]; if8n.control = op; end
        endcase
    endtask

    task automatic drive_or(input int sel, input logic r);
        case (sel)
            0: if8.out_ready = r;
            1: if64.out_ready = r;
            default: if8n.out_ready = r;
        endcase
    endtask

    // ---------------- reference model ----------------
    task automatic ref_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op, output logic [63:0] res, output logic cout,
                          output logic ovf, output logic ill, output int lat);
        int w;
        bit den;
        logic [63:0] m;
        logic [64:0] s65;
        logic [127:0] prod;
        logic signed [129:0] sa, sb, sr, lo, hi;
        w   = width_of(sel);
        den = (sel != 2);
        m   = mask_of(w);
        sa  = sx(a, w);
        sb  = sx(b, w);
        lo  = -(130'sd1 <<< (w - 1));
        hi  = (130'sd1 <<< (w - 1)) - 130'sd1;
        res = '0; cout = 1'b0; ovf = 1'b0; ill = 1'b0; lat = 1;
        case (op)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd12: res = ~(a | b) & m;
            4'd2: begin
                s65  = {1'b0, a} + {1'b0, b};
                res  = s65[63:0] & m;
                cout = s65 > {1'b0, m};
                sr   = sa + sb;
                ovf  = (sr < lo) || (sr > hi);
            end
            4'd6: begin
                res  = (a - b) & m;
                cout = (a >= b);
                sr   = sa - sb;
                ovf  = (sr < lo) || (sr > hi);
            end
            4'd7: begin
                res  = (sa < sb) ? 64'd1 : 64'd0;
                cout = (a >= b);
            end
            4'd8: begin
                prod = {64'd0, a} * {64'd0, b};
                res  = prod[63:0] & m;
                lat  = w + 1;
            end
            4'd10: if (den) begin res = (b == 0) ? m : a / b; lat = w + 1; end else ill = 1'b1;
            4'd11: if (den) begin res = (b == 0) ? a : a % b; lat = w + 1; end else ill = 1'b1;
            default: ill = 1'b1;
        endcase
    endtask

    // Issue one operation, wait for its result, hold out_ready low for
    // `hold` cycles (with a stray request on the input), then consume.
    task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op, input int hold);
        logic [63:0] e_res, got;
        logic e_cout, e_ovf, e_ill;
        int e_lat, lat;
        bit done;
        out_t o, o2;
        ref_op(sel, a, b, op, e_res, e_cout, e_ovf, e_ill, e_lat);
        exp_q.push_back(e_res);

        @(negedge clk);
        o = sample(sel);
        chk("idle_ready", {63'd0, o.in_ready}, 64'd1);
        drive_in(sel, 1'b1, a, b, op);
        @(posedge clk);
        #1;
        drive_in(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)));

        lat  = 0;
        done = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            o = sample(sel);
            if (o.out_valid) done = 1;
            else chk("busy_ready", {63'd0, o.in_ready}, 64'd0);
        end
        chk("latency", 64'(lat), 64'(e_lat));
        got = exp_q.pop_front();
        chk("result", o.result, got);
        chk("cout", {63'd0, o.cout}, {63'd0, e_cout});
        chk("zero", {63'd0, o.zero}, {63'd0, (got == 64'd0)});
        chk("overflow", {63'd0, o.overflow}, {63'd0, e_ovf});
        chk("illegal", {63'd0, o.illegal}, {63'd0, e_ill});
        chk("done_ready", {63'd0, o.in_ready}, 64'd0);

        for (int h = 0; h < hold; h++) begin
            drive_in(sel, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 4'b0010);
            @(negedge clk);
            o2 = sample(sel);
            chk("hold_result", o2.result, got);
            chk("hold_valid", {63'd0, o2.out_valid}, 64'd1);
            chk("hold_ready", {63'd0, o2.in_ready}, 64'd0);
        end
        drive_in(sel, 1'b0, 64'd0, 64'd0, 4'd0);
        drive_or(sel, 1'b1);
        @(posedge clk);
        #1;
        drive_or(sel, 1'b0);
        @(negedge clk);
        o2 = sample(sel);
        chk("consumed_valid", {63'd0, o2.out_valid}, 64'd0);
        chk("consumed_ready", {63'd0, o2.in_ready}, 64'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        out_t o;
        int n_rand[3];
        logic [63:0] ra, rb, m;
        n_rand = '{40, 25, 30};

        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive_in(s, 1'b0, 64'd0, 64'd0, 4'd0);
            drive_or(s, 1'b0);
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            o = sample(s);
            chk("rst_valid", {63'd0, o.out_valid}, 64'd0);
            chk("rst_result", o.result, 64'd0);
            chk("rst_flags", {60'd0, o.cout, o.zero, o.overflow, o.illegal}, 64'd0);
            chk("rst_ready", {63'd0, o.in_ready}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            o = sample(s);
            chk("post_rst_ready", {63'd0, o.in_ready}, 64'd1);
        end

        // SUB overflow corner, MULU latency, divide by zero, REMU
        run_op(0, 64'h80, 64'h01, 4'b0110, 0);
        run_op(0, 64'd13, 64'd11, 4'b1000, 0);
        run_op(0, 64'd200, 64'd0, 4'b1010, 0);
        run_op(0, 64'd200, 64'd7, 4'b1011, 0);
        // SLT result held under back-pressure
        run_op(0, 64'hFF, 64'd1, 4'b0111, 5);
        // illegal opcode, and divide with divide disabled
        run_op(0, 64'd5, 64'd3, 4'b0101, 0);
        run_op(2, 64'd200, 64'd7, 4'b1010, 0);
        // wide corners
        run_op(1, 64'h8000_0000_0000_0000, 64'h1, 4'b0110, 0);
        run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 0);
        run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b1011, 0);

        // reset in the middle of a multiply discards it
        @(negedge clk);
        drive_in(0, 1'b1, 64'd13, 64'd11, 4'b1000);
        @(posedge clk);
        #1;
        drive_in(0, 1'b0, 64'd0, 64'd0, 4'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = sample(0);
        chk("midrst_valid", {63'd0, o.out_valid}, 64'd0);
        chk("midrst_ready", {63'd0, o.in_ready}, 64'd0);
        @(negedge clk);
        o = sample(0);
        chk("midrst_ready2", {63'd0, o.in_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        o = sample(0);
        chk("midrst_release_ready", {63'd0, o.in_ready}, 64'd1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            o = sample(0);
            chk("discarded_valid", {63'd0, o.out_valid}, 64'd0);
        end
        run_op(0, 64'd3, 64'd4, 4'b0010, 0);

        // randomized operations on every instance
        for (int s = 0; s < 3; s++) begin
            m = mask_of(width_of(s));
            for (int i = 0; i < n_rand[s]; i++) begin
                ra = {$urandom, $urandom} & m;
                rb = {$urandom, $urandom} & m;
                if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(0, 5));
                run_op(s, ra, rb, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
